// File: rtl/wb_pipeline.sv
// RV32I write-back stage: waits on data-memory load responses, aligns and extends load data, and drives the register-file write port.
// Optional macro WB_LOAD_TIMEOUT_EN abandons a load after LOAD_TIMEOUT wait cycles and pulses err_out.
module wb_pipeline #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        RegWEn_in,
  input  logic [4:0]  AddrD_in,
  input  logic [1:0]  WBSel_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] pcPlus4_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        RegWEn_out,
  output logic [4:0]  AddrD_out,
  output logic [31:0] DataD_out,
  output logic        stall_out,
  output logic        err_out
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  hold_addr_q, hold_addr_d;
  logic [2:0]  hold_f3_q, hold_f3_d;
  logic [1:0]  hold_off_q, hold_off_d;
  logic        regwen_q, regwen_d;
  logic [4:0]  addrd_q, addrd_d;
  logic [31:0] datad_q, datad_d;
  logic        stall_c;
  logic        is_load;

  // Byte/halfword lane select and extension; off[0] is ignored for halfwords.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic        [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = off[1] ? word[31:16] : word[15:0];
    sb = signed'(b);
    sh = signed'(h);
    case (f3)
      3'b000:  r = 32'(sb);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(sh);
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign is_load = valid_in & RegWEn_in & (WBSel_in == 2'b00);

`ifdef WB_LOAD_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_f3_d   = hold_f3_q;
    hold_off_d  = hold_off_q;
    regwen_d    = 1'b0;
    addrd_d     = addrd_q;
    datad_d     = datad_q;
    stall_c     = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (is_load) begin
          if (dmem_rvalid) begin
            regwen_d = (AddrD_in != 5'd0);
            addrd_d  = AddrD_in;
            datad_d  = align_load(dmem_rdata, funct3_in, alu_in[1:0]);
          end else begin
            hold_addr_d = AddrD_in;
            hold_f3_d   = funct3_in;
            hold_off_d  = alu_in[1:0];
            stall_c     = 1'b1;
            state_d     = WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_d       = 8'd0;
`endif
          end
        end else if (valid_in && RegWEn_in) begin
          regwen_d = (AddrD_in != 5'd0);
          addrd_d  = AddrD_in;
          datad_d  = (WBSel_in == 2'b10) ? pcPlus4_in : alu_in;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          regwen_d = (hold_addr_q != 5'd0);
          addrd_d  = hold_addr_q;
          datad_d  = align_load(dmem_rdata, hold_f3_q, hold_off_q);
          state_d  = IDLE;
        end else begin
          stall_c = 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
          // Abandon on the wait cycle that brings the count to LOAD_TIMEOUT;
          // err_out and the dropped stall appear together in the next cycle.
          if (cnt_q == 8'(LOAD_TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_addr_q <= 5'd0;
      hold_f3_q   <= 3'd0;
      hold_off_q  <= 2'd0;
      regwen_q    <= 1'b0;
      addrd_q     <= 5'd0;
      datad_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_f3_q   <= hold_f3_d;
      hold_off_q  <= hold_off_d;
      regwen_q    <= regwen_d;
      addrd_q     <= addrd_d;
      datad_q     <= datad_d;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_out = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |LOAD_TIMEOUT;
  assign err_out        = 1'b0;
`endif

  // Reset gates the stall combinationally so a dropped load releases upstream at once.
  assign stall_out  = stall_c & ~reset;
  assign RegWEn_out = regwen_q;
  assign AddrD_out  = addrd_q;
  assign DataD_out  = datad_q;

endmodule
